// File: rtl/instruction_pkg.sv
// Shared instruction widths, length-code fields and serializer states.
package instruction_pkg;

  localparam int LEN_MSB  = 23;
  localparam int LEN_LSB  = 22;
  localparam int WORD_W   = 8;
  localparam int OPCODE_W = 24;

  localparam logic [1:0] LEN_ILLEGAL = 2'b11;

  typedef enum logic {
    IDLE,
    SEND
  } iser_state_t;

endpackage

// File: rtl/instruction_serializer.sv
// Packs a 24-bit opcode into 1-3 MSB-first bytes over valid/ready.
// Define ISER_PREFETCH_EN to accept the next opcode on the final byte.
module instruction_serializer
  import instruction_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                op_valid,
  output logic                op_ready,
  output logic [WORD_W-1:0]   curr_wrd,
  output logic                wrd_valid,
  input  logic                wrd_ready,
  output logic                busy,
  output logic                err
);

  iser_state_t         state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [1:0]          len_q, len_d;
  logic [1:0]          idx_q, idx_d;
  logic                err_d;

  logic last;
  logic fire;
  logic accept;
  logic illegal;

  assign last      = (idx_q == len_q);
  assign wrd_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign fire      = wrd_valid && wrd_ready;
  assign illegal   = (opcode[LEN_MSB:LEN_LSB] == LEN_ILLEGAL);

`ifdef ISER_PREFETCH_EN
  assign op_ready = !rst &&
    ((state_q == IDLE) ||
     ((state_q == SEND) && last && wrd_ready));
`else
  assign op_ready = !rst && (state_q == IDLE);
`endif

  assign accept = op_valid && op_ready;

  always_comb begin
    case (idx_q)
      2'd0:    curr_wrd = op_q[23:16];
      2'd1:    curr_wrd = op_q[15:8];
      default: curr_wrd = op_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            op_d    = opcode;
            len_d   = opcode[LEN_MSB:LEN_LSB];
            idx_d   = 2'd0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (fire) begin
          if (last) begin
            state_d = IDLE;
`ifdef ISER_PREFETCH_EN
            // Chain straight into the next instruction with no gap.
            if (accept) begin
              if (illegal) begin
                err_d = 1'b1;
              end else begin
                op_d    = opcode;
                len_d   = opcode[LEN_MSB:LEN_LSB];
                idx_d   = 2'd0;
                state_d = SEND;
              end
            end
`endif
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_instruction_serializer.sv
// Directed bench for instruction_serializer.
module tb_instruction_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] opcode;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  curr_wrd;
  logic        wrd_valid;
  logic        wrd_ready;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  instruction_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .curr_wrd  (curr_wrd),
    .wrd_valid (wrd_valid),
    .wrd_ready (wrd_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] b);
    check({tag, "_valid"}, 32'(wrd_valid), 32'd1);
    check({tag, "_byte"}, 32'(curr_wrd), 32'(b));
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = '0;
    op_valid  = 1'b0;
    wrd_ready = 1'b1;

    tick();
    check("rst_op_ready_c1", 32'(op_ready), 32'd0);
    tick();
    check("rst_op_ready_c2", 32'(op_ready), 32'd0);
    check("rst_wrd_valid", 32'(wrd_valid), 32'd0);
    check("rst_curr_wrd", 32'(curr_wrd), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_op_ready", 32'(op_ready), 32'd1);

    // 3-byte instruction
    opcode   = 24'h8ABCDE;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk_byte("b3_0", 8'h8A);
    check("b3_busy0", 32'(busy), 32'd1);
    check("b3_op_ready", 32'(op_ready), 32'd0);
    tick();
    chk_byte("b3_1", 8'hBC);
    check("b3_busy1", 32'(busy), 32'd1);
    tick();
    chk_byte("b3_2", 8'hDE);
    check("b3_busy2", 32'(busy), 32'd1);
    tick();
    check("b3_done_valid", 32'(wrd_valid), 32'd0);
    check("b3_done_busy", 32'(busy), 32'd0);

    // 1-byte instruction
    opcode   = 24'h05FFFF;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk_byte("b1_0", 8'h05);
    tick();
    check("b1_done_valid", 32'(wrd_valid), 32'd0);
    check("b1_op_ready", 32'(op_ready), 32'd1);

    // 2-byte with backpressure
    opcode    = 24'h412233;
    op_valid  = 1'b1;
    wrd_ready = 1'b0;
    tick();
    op_valid = 1'b0;
    chk_byte("bp_0a", 8'h41);
    tick();
    chk_byte("bp_0b", 8'h41);
    tick();
    chk_byte("bp_0c", 8'h41);
    wrd_ready = 1'b1;
    tick();
    chk_byte("bp_1", 8'h22);
    tick();
    check("bp_done_valid", 32'(wrd_valid), 32'd0);

    // illegal length code
    opcode   = 24'hC01234;
    op_valid = 1'b1;
    #1;
    check("ill_op_ready_n", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    check("ill_err_n1", 32'(err), 32'd1);
    check("ill_valid_n1", 32'(wrd_valid), 32'd0);
    check("ill_op_ready_n1", 32'(op_ready), 32'd1);
    tick();
    check("ill_err_n2", 32'(err), 32'd0);
    check("ill_valid_n2", 32'(wrd_valid), 32'd0);

    // back-to-back
    opcode   = 24'h8A0000;
    op_valid = 1'b1;
    tick();
    opcode = 24'h070000;
    chk_byte("bb_0", 8'h8A);
    check("bb_op_ready_0", 32'(op_ready), 32'd0);
    tick();
    chk_byte("bb_1", 8'h00);
    tick();
    chk_byte("bb_2", 8'h00);
`ifdef ISER_PREFETCH_EN
    check("bb_op_ready_last", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    chk_byte("bb_next", 8'h07);
`else
    check("bb_op_ready_last", 32'(op_ready), 32'd0);
    tick();
    check("bb_gap_valid", 32'(wrd_valid), 32'd0);
    check("bb_gap_op_ready", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    chk_byte("bb_next", 8'h07);
`endif
    tick();
    check("bb_done_valid", 32'(wrd_valid), 32'd0);

    // reset mid-send
    opcode   = 24'h8ABCDE;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk_byte("rm_0", 8'h8A);
    rst = 1'b1;
    #1;
    check("rm_op_ready", 32'(op_ready), 32'd0);
    tick();
    check("rm_valid", 32'(wrd_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_curr_wrd", 32'(curr_wrd), 32'h00);
    rst = 1'b0;
    tick();
    check("rm_valid2", 32'(wrd_valid), 32'd0);

    // reset beats op_valid
    rst      = 1'b1;
    opcode   = 24'h8ABCDE;
    op_valid = 1'b1;
    #1;
    check("rv_op_ready", 32'(op_ready), 32'd0);
    tick();
    rst      = 1'b0;
    op_valid = 1'b0;
    check("rv_valid", 32'(wrd_valid), 32'd0);
    tick();
    check("rv_valid2", 32'(wrd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_serializer.md
# instruction_serializer

Converts one packed 24-bit instruction word into the variable-length byte stream consumed by `instruction_register`. It emits 1–3 bytes, most-significant byte first, with the length taken from bits [23:22] of the opcode. The block sits on the program-load / fetch path, ahead of the byte-wide instruction input. A valid/ready handshake on both sides allows stalls from either end.

## Interface
- Parameters: none; widths are fixed by the shared instruction package.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `opcode`  in  24  instruction word; bits [23:16] form the first byte.
- `op_valid`  in  1  `opcode` is presented.
- `op_ready`  out  1  block accepts `opcode` this cycle. Combinational.
- `curr_wrd`  out  8  current output byte.
- `wrd_valid`  out  1  `curr_wrd` is valid.
- `wrd_ready`  in  1  downstream consumes `curr_wrd` this cycle.
- `busy`  out  1  an instruction is being emitted.
- `err`  out  1  one-cycle pulse when an illegal length code is accepted.

## Operation
- Length code `opcode[23:22]`: 00 → 1 byte, 01 → 2 bytes, 10 → 3 bytes, 11 → illegal.
- Byte order: `opcode[23:16]`, then `[15:8]`, then `[7:0]`. Unused trailing bytes are never emitted.
- Registered state: holding register `op_q[23:0]`, length `len_q[1:0]` (byte count minus 1), byte index `idx[1:0]`, FSM state.
- FSM states are IDLE and SEND.
- IDLE:
  - `op_ready` = 1.
  - On `op_valid` with a legal code: latch `op_q` and `len_q`, set `idx` = 0, go to SEND.
  - On `op_valid` with code 11: the handshake completes, `op_q` is not updated, `err` pulses on the next cycle, and the FSM stays in IDLE.
- SEND:
  - `wrd_valid` = 1 and `busy` = 1.
  - `curr_wrd` = byte `idx` of `op_q`.
  - On `wrd_valid && wrd_ready`: if `idx == len_q`, go to IDLE; otherwise increment `idx`.
- `curr_wrd` holds stable while `wrd_valid` is high and `wrd_ready` is low.
- `idx` never exceeds 2. No wrap-around is possible.
- With `op_valid` low in IDLE, all state holds.

## Timing
- Reset values: `wrd_valid`=0, `curr_wrd`=8'h00, `busy`=0, `err`=0, `op_q`=0, `idx`=0, state IDLE.
- `op_ready` = 0 in every cycle that `rst` is high.
- Reset mid-SEND abandons the partial instruction. From the cycle after `rst` is sampled, `wrd_valid` = 0.
- Latency: opcode accepted at cycle N → first byte valid at N+1.
- With `wrd_ready` held at 1, an L-byte instruction occupies cycles N+1 .. N+L.
- Back-to-back instructions (macro absent): there is one idle output cycle between the last byte of one instruction and the first byte of the next.
- `err` is high for exactly one cycle, at N+1.
- When `rst` and `op_valid` are high in the same cycle, reset wins and the opcode is not accepted.

## Configuration
- Macro `ISER_PREFETCH_EN`.
- **Defined:**
  - `op_ready` = IDLE || (SEND && `idx == len_q` && `wrd_ready`).
  - A new opcode is accepted in the same cycle as the final byte handshake, so the next first byte is valid at N+1 with zero gap.
  - An illegal code accepted this way sends the FSM to IDLE and pulses `err`.
  - Adds a combinational path from `wrd_ready` to `op_ready`.
- **Absent:** `op_ready` = IDLE only, giving the one-cycle gap described under Timing.

## Structure
- Shared package `instruction_pkg` holds:
  - `LEN_MSB`=23 and `LEN_LSB`=22.
  - `LEN_ILLEGAL`=2'b11.
  - `WORD_W`=8 and `OPCODE_W`=24.
  - The state enum `{IDLE, SEND}`.
- The receiver uses the same package.
- No sub-module: the byte mux is a three-way case on `idx`, kept inline.

## Test plan
- **Reset:** hold `rst` for 2 cycles → `wrd_valid`=0, `curr_wrd`=0x00, `op_ready`=0 during reset, `op_ready`=1 on the first cycle after.
- **3-byte instruction:** present 0x8ABCDE with `wrd_ready`=1 at cycle N → bytes 0x8A, 0xBC, 0xDE at N+1..N+3; `busy` high at N+1..N+3.
- **1-byte instruction:** present 0x05FFFF → single byte 0x05 at N+1, then IDLE; 0xFF is never emitted.
- **Backpressure:** present 0x412233 and hold `wrd_ready`=0 for 3 cycles from N+1 → `curr_wrd`=0x41 stable throughout, then 0x22; 0x33 is never emitted.
- **Illegal code:** present 0xC01234 → `err`=1 at N+1 only, `wrd_valid` stays 0, `op_ready`=1 at N+1.
- **Back-to-back and reset mid-send:**
  - Send 0x8A0000 then 0x0700000.. i.e. 0x070000: with `ISER_PREFETCH_EN`, 0x07 is valid the cycle after 0x00; without it, after one idle cycle.
  - Assert `rst` after the 1st byte → no further bytes are emitted.
